// File: rtl/soc_decerr_responder_pkg.sv
// Shared SoC definitions used by the default/error responder:
// ID widths, the DECERR response code and the FSM state encodings.
package soc_decerr_responder_pkg;

  localparam int unsigned IdWidthMaster = 4;
  localparam int unsigned NumMasters    = 2;
  // The crossbar prepends the master index to each ID on its slave side.
  localparam int unsigned IdWidthSlave  = IdWidthMaster + $clog2(NumMasters);
  localparam int unsigned IdWidth       = IdWidthSlave;

  localparam logic [1:0]  RespDecerr      = 2'b11;
  localparam logic [63:0] RespDataDefault = 64'hCA11AB1EBADCAB1E;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/soc_decerr_rd_burst.sv
// Read side of the error responder: accepts one AR at a time and returns
// len+1 beats, flagging the final one with r_last.
module soc_decerr_rd_burst
  import soc_decerr_responder_pkg::*;
#(
  parameter int unsigned IdWidth = IdWidthSlave
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ar_valid_i,
  output logic               ar_ready_o,
  input  logic [IdWidth-1:0] ar_id_i,
  input  logic [7:0]         ar_len_i,
  output logic               r_valid_o,
  input  logic               r_ready_i,
  output logic [IdWidth-1:0] r_id_o,
  output logic               r_last_o
);

  rd_state_e          state_q, state_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         beat_q, beat_d;
  logic               at_last;

  assign at_last = (beat_q == len_q);

  // NOTE: every always_comb output gets a default first so no path
  // through the case statement leaves a signal unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    len_d      = len_q;
    beat_d     = beat_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) begin
          id_d    = ar_id_i;
          len_d   = ar_len_i;
          beat_d  = 8'd0;
          state_d = R_DATA;
        end
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        // The counter stops at len, so len=255 never wraps it.
        if (r_ready_i) begin
          if (at_last) state_d = R_IDLE;
          else         beat_d  = beat_q + 8'd1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= R_IDLE;
      id_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  assign r_id_o   = id_q;
  assign r_last_o = (state_q == R_DATA) && at_last;

endmodule

// File: rtl/soc_decerr_responder.sv
// Default slave of the SoC crossbar: answers unmapped accesses with DECERR
// and logs the last offending address plus a saturating error count.
module soc_decerr_responder
  import soc_decerr_responder_pkg::*;
#(
  parameter int unsigned           IdWidth   = IdWidthSlave,
  parameter int unsigned           AddrWidth = 64,
  parameter int unsigned           DataWidth = 64,
  parameter logic [DataWidth-1:0]  RespData  = RespDataDefault,
  parameter int unsigned           CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_write_o,
  output logic [CntWidth-1:0]  err_cnt_o
);

  wr_state_e            wr_state_q, wr_state_d;
  logic [IdWidth-1:0]   b_id_q, b_id_d;
  logic [AddrWidth-1:0] err_addr_q, err_addr_d;
  logic                 err_write_q, err_write_d;
  logic [CntWidth-1:0]  err_cnt_q, err_cnt_d;
  logic                 aw_hs, ar_hs;
  logic [1:0]           n_accepted;
  logic [CntWidth:0]    cnt_sum;

  always_comb begin
    wr_state_d = wr_state_q;
    b_id_d     = b_id_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) begin
          b_id_d     = aw_id_i;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) wr_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  soc_decerr_rd_burst #(
    .IdWidth (IdWidth)
  ) u_rd_burst (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .ar_id_i    (ar_id_i),
    .ar_len_i   (ar_len_i),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .r_id_o     (r_id_o),
    .r_last_o   (r_last_o)
  );

  assign aw_hs      = aw_valid_i && aw_ready_o;
  assign ar_hs      = ar_valid_i && ar_ready_o;
  assign n_accepted = {1'b0, aw_hs} + {1'b0, ar_hs};
  assign cnt_sum    = {1'b0, err_cnt_q} + (CntWidth+1)'(n_accepted);

  // A write accepted alongside a read takes priority in the log.
  always_comb begin
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    if (aw_hs) begin
      err_addr_d  = aw_addr_i;
      err_write_d = 1'b1;
    end else if (ar_hs) begin
      err_addr_d  = ar_addr_i;
      err_write_d = 1'b0;
    end
    err_cnt_d = cnt_sum[CntWidth] ? {CntWidth{1'b1}} : cnt_sum[CntWidth-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q  <= W_IDLE;
      b_id_q      <= '0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      b_id_q      <= b_id_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign b_id_o      = b_id_q;
  assign b_resp_o    = RespDecerr;
  assign r_data_o    = RespData;
  assign r_resp_o    = RespDecerr;
  assign err_addr_o  = err_addr_q;
  assign err_write_o = err_write_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_soc_decerr_responder.sv
// Randomized self-checking bench for soc_decerr_responder; expectations come
// from a transaction-level model of the responder's rules.
module tb_soc_decerr_responder;

  localparam logic [63:0] RESP_DATA = 64'hCA11AB1EBADCAB1E;
  localparam int unsigned CNT_MAX   = 65535;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        aw_valid_i, aw_ready_o;
  logic [4:0]  aw_id_i;
  logic [63:0] aw_addr_i;
  logic        w_valid_i, w_ready_o, w_last_i;
  logic        b_valid_o, b_ready_i;
  logic [4:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i, ar_ready_o;
  logic [4:0]  ar_id_i;
  logic [63:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic        r_valid_o, r_ready_i;
  logic [4:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic [63:0] err_addr_o;
  logic        err_write_o;
  logic [15:0] err_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  // Transaction-level model of the error log.
  int unsigned exp_cnt   = 0;
  logic [63:0] exp_addr  = '0;
  logic        exp_write = 1'b0;

  always #5 clk_i = ~clk_i;

  soc_decerr_responder dut (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .aw_valid_i (aw_valid_i), .aw_ready_o (aw_ready_o), .aw_id_i (aw_id_i),
    .aw_addr_i (aw_addr_i), .w_valid_i (w_valid_i), .w_ready_o (w_ready_o),
    .w_last_i (w_last_i), .b_valid_o (b_valid_o), .b_ready_i (b_ready_i),
    .b_id_o (b_id_o), .b_resp_o (b_resp_o), .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o), .ar_id_i (ar_id_i), .ar_addr_i (ar_addr_i),
    .ar_len_i (ar_len_i), .r_valid_o (r_valid_o), .r_ready_i (r_ready_i),
    .r_id_o (r_id_o), .r_data_o (r_data_o), .r_resp_o (r_resp_o),
    .r_last_o (r_last_o), .err_addr_o (err_addr_o), .err_write_o (err_write_o),
    .err_cnt_o (err_cnt_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void model_accept(input logic [63:0] addr, input logic is_wr,
                                       input int unsigned n);
    exp_cnt   = (exp_cnt + n > CNT_MAX) ? CNT_MAX : exp_cnt + n;
    exp_addr  = addr;
    exp_write = is_wr;
  endfunction

  task automatic do_write(input logic [4:0] id, input logic [63:0] addr,
                          input int nbeats, input bit gaps);
    int sent = 0;
    int cyc  = 0;
    int bstall;
    aw_valid_i = 1'b1; aw_id_i = id; aw_addr_i = addr;
    vectors++;
    if (aw_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL wr_aw_ready: got %b exp 1", aw_ready_o);
    end
    step();
    aw_valid_i = 1'b0;
    model_accept(addr, 1'b1, 1);
    vectors++;
    if (err_addr_o !== exp_addr || err_write_o !== exp_write || err_cnt_o !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL wr_log: got %h/%b/%0d exp %h/%b/%0d", err_addr_o, err_write_o,
               err_cnt_o, exp_addr, exp_write, exp_cnt);
    end
    while (sent < nbeats && cyc < 200) begin
      w_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      w_last_i  = (sent == nbeats - 1);
      vectors++;
      if (w_ready_o !== 1'b1 || b_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL wr_data_phase: w_ready %b b_valid %b exp 1/0", w_ready_o, b_valid_o);
      end
      if (w_valid_i) sent++;
      step();
      cyc++;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    bstall = gaps ? $urandom_range(0, 2) : 0;
    for (int i = 0; i <= bstall; i++) begin
      b_ready_i = (i == bstall);
      vectors++;
      if (b_valid_o !== 1'b1 || b_id_o !== id || b_resp_o !== 2'b11 || w_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL wr_b: valid %b id %0d resp %b w_ready %b exp 1/%0d/11/0",
                 b_valid_o, b_id_o, b_resp_o, w_ready_o, id);
      end
      step();
    end
    b_ready_i = 1'b0;
    vectors++;
    if (b_valid_o !== 1'b0 || aw_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_done: b_valid %b aw_ready %b exp 0/1", b_valid_o, aw_ready_o);
    end
  endtask

  // stall_mode: 0 = always ready, 1 = toggle every cycle, 2 = random
  task automatic do_read(input logic [4:0] id, input logic [63:0] addr,
                         input int len, input int stall_mode);
    int beats = 0;
    int cyc   = 0;
    ar_valid_i = 1'b1; ar_id_i = id; ar_addr_i = addr; ar_len_i = 8'(len);
    vectors++;
    if (ar_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL rd_ar_ready: got %b exp 1", ar_ready_o);
    end
    step();
    ar_valid_i = 1'b0;
    model_accept(addr, 1'b0, 1);
    vectors++;
    if (err_addr_o !== exp_addr || err_write_o !== exp_write || err_cnt_o !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL rd_log: got %h/%b/%0d exp %h/%b/%0d", err_addr_o, err_write_o,
               err_cnt_o, exp_addr, exp_write, exp_cnt);
    end
    while (beats <= len && cyc < 2000) begin
      case (stall_mode)
        0:       r_ready_i = 1'b1;
        1:       r_ready_i = cyc[0];
        default: r_ready_i = 1'($urandom_range(0, 1));
      endcase
      vectors++;
      if (r_valid_o !== 1'b1 || r_last_o !== (beats == len) || r_id_o !== id ||
          r_data_o !== RESP_DATA || r_resp_o !== 2'b11) begin
        miscompares++;
        $display("FAIL rd_beat%0d: valid %b last %b id %0d data %h resp %b exp 1/%b/%0d/%h/11",
                 beats, r_valid_o, r_last_o, r_id_o, r_data_o, r_resp_o,
                 (beats == len), id, RESP_DATA);
        break;
      end
      if (r_ready_i) beats++;
      step();
      cyc++;
    end
    r_ready_i = 1'b0;
    vectors++;
    if (beats != len + 1 || r_valid_o !== 1'b0 || ar_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_done: beats %0d r_valid %b ar_ready %b exp %0d/0/1",
               beats, r_valid_o, ar_ready_o, len + 1);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; w_valid_i = 0; w_last_i = 0;
    b_ready_i = 0; ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0;
    r_ready_i = 0;
    #13;
    vectors++;
    if (aw_ready_o !== 1'b1 || ar_ready_o !== 1'b1 || w_ready_o !== 1'b0 ||
        b_valid_o !== 1'b0 || r_valid_o !== 1'b0 || r_last_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hs: aw_rdy %b ar_rdy %b w_rdy %b b_vld %b r_vld %b r_last %b exp 1/1/0/0/0/0",
               aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, r_last_o);
    end
    vectors++;
    if (b_id_o !== 5'd0 || r_id_o !== 5'd0 || err_addr_o !== 64'd0 ||
        err_write_o !== 1'b0 || err_cnt_o !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_regs: b_id %0d r_id %0d addr %h wr %b cnt %0d exp all 0",
               b_id_o, r_id_o, err_addr_o, err_write_o, err_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    do_write(5'd5, 64'h0000_0000_5000_0000, 1, 1'b0);
  endtask

  task automatic test_read_burst();
    do_read(5'd3, 64'h0000_0000_6000_0040, 3, 0);
  endtask

  task automatic test_long_burst_stall();
    do_read(5'd21, 64'hFFFF_0000_0000_1000, 255, 1);
  endtask

  task automatic test_simultaneous();
    int wsent = 0, bgot = 0, rbeats = 0;
    logic [63:0] wa = 64'h0000_0040_1234_5678;
    aw_valid_i = 1'b1; aw_id_i = 5'd9;  aw_addr_i = wa;
    ar_valid_i = 1'b1; ar_id_i = 5'd17; ar_addr_i = 64'h0000_0040_8765_4320;
    ar_len_i = 8'd2;
    vectors++;
    if (aw_ready_o !== 1'b1 || ar_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_ready: aw %b ar %b exp 1/1", aw_ready_o, ar_ready_o);
    end
    step();
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    model_accept(wa, 1'b1, 2);
    vectors++;
    if (err_addr_o !== exp_addr || err_write_o !== 1'b1 || err_cnt_o !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL sim_log: got %h/%b/%0d exp %h/1/%0d", err_addr_o, err_write_o,
               err_cnt_o, exp_addr, exp_cnt);
    end
    for (int cyc = 0; cyc < 300 && !(bgot == 1 && rbeats == 3); cyc++) begin
      w_valid_i = (wsent < 2) && 1'($urandom_range(0, 1));
      w_last_i  = (wsent == 1);
      b_ready_i = 1'($urandom_range(0, 1));
      r_ready_i = 1'($urandom_range(0, 1));
      vectors++;
      if (r_valid_o !== (rbeats < 3) || (rbeats < 3 && (r_last_o !== (rbeats == 2) || r_id_o !== 5'd17))) begin
        miscompares++;
        $display("FAIL sim_r%0d: valid %b last %b id %0d exp %b/%b/17",
                 rbeats, r_valid_o, r_last_o, r_id_o, (rbeats < 3), (rbeats == 2));
      end
      vectors++;
      if (w_ready_o !== (wsent < 2) || b_valid_o !== (wsent == 2 && bgot == 0) ||
          (b_valid_o === 1'b1 && b_id_o !== 5'd9)) begin
        miscompares++;
        $display("FAIL sim_w: w_ready %b b_valid %b b_id %0d exp %b/%b/9",
                 w_ready_o, b_valid_o, b_id_o, (wsent < 2), (wsent == 2 && bgot == 0));
      end
      if (w_valid_i && w_ready_o) wsent++;
      if (b_valid_o && b_ready_i) bgot++;
      if (r_valid_o && r_ready_i) rbeats++;
      step();
    end
    w_valid_i = 0; w_last_i = 0; b_ready_i = 0; r_ready_i = 0;
    vectors++;
    if (wsent != 2 || bgot != 1 || rbeats != 3) begin
      miscompares++;
      $display("FAIL sim_done: w %0d b %0d r %0d exp 2/1/3", wsent, bgot, rbeats);
    end
  endtask

  task automatic test_w_before_aw();
    w_valid_i = 1'b1; w_last_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (w_ready_o !== 1'b0) begin
        miscompares++; $display("FAIL early_w%0d: w_ready %b exp 0", i, w_ready_o);
      end
      step();
    end
    aw_valid_i = 1'b1; aw_id_i = 5'd30; aw_addr_i = 64'h0000_0000_DEAD_0000;
    step();
    aw_valid_i = 1'b0;
    model_accept(64'h0000_0000_DEAD_0000, 1'b1, 1);
    vectors++;
    if (w_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL early_w_accept: w_ready %b exp 1", w_ready_o);
    end
    step();
    w_valid_i = 1'b0; w_last_i = 1'b0; b_ready_i = 1'b1;
    vectors++;
    if (b_valid_o !== 1'b1 || b_id_o !== 5'd30 || err_cnt_o !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL early_w_b: valid %b id %0d cnt %0d exp 1/30/%0d",
               b_valid_o, b_id_o, err_cnt_o, exp_cnt);
    end
    step();
    b_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    ar_valid_i = 1'b1; ar_id_i = 5'd12; ar_addr_i = 64'h1000; ar_len_i = 8'd7;
    step();
    ar_valid_i = 1'b0;
    r_ready_i  = 1'b1;
    step();
    vectors++;
    if (r_valid_o !== 1'b1 || r_last_o !== 1'b0) begin
      miscompares++; $display("FAIL mid_beat2: valid %b last %b exp 1/0", r_valid_o, r_last_o);
    end
    rst_ni = 1'b0;
    #1;
    exp_cnt = 0; exp_addr = '0; exp_write = 1'b0;
    vectors++;
    if (r_valid_o !== 1'b0 || err_cnt_o !== 16'd0 || err_addr_o !== 64'd0) begin
      miscompares++;
      $display("FAIL mid_reset: r_valid %b cnt %0d addr %h exp 0/0/0", r_valid_o, err_cnt_o, err_addr_o);
    end
    r_ready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    vectors++;
    if (ar_ready_o !== 1'b1 || r_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_release: ar_ready %b r_valid %b exp 1/0", ar_ready_o, r_valid_o);
    end
    do_read(5'd4, 64'h2000, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [4:0]  id   = 5'($urandom);
      logic [63:0] addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        do_write(id, addr, $urandom_range(1, 4), 1'b1);
      else
        do_read(id, addr, $urandom_range(0, 15), 2);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_long_burst_stall();
    test_simultaneous();
    test_w_before_aw();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
